// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   // One fetched word together with the address of the following instruction.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fetch_entry_t;

   typedef enum logic {
      RUN,
      WAIT_DS
   } redirect_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with occupancy count and flush.
module fetch_fifo
   import if_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               push,
   input  fetch_entry_t       wdata,
   input  logic               pop,
   output fetch_entry_t       rdata,
   output logic [CNT_W-1:0]   count
);

   fetch_entry_t mem [DEPTH];
   logic [PTR_W-1:0] rd_q, wr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A push into a full FIFO is allowed only when the head leaves in the same cycle.
   always_comb begin
      do_pop  = pop && (cnt_q != '0);
      do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
   end

   // Pointer and occupancy state; flush empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= ptr_inc(wr_q);
         if (do_pop)  rd_q <= ptr_inc(rd_q);
         cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage array; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_q] <= wdata;
   end

   assign rdata = mem[rd_q];
   assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited req/gnt fetches, buffers returned
// words with PC+4 and handles decode redirects with an optional single delay slot.
module fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned BUF_DEPTH  = 2,
   parameter int unsigned DELAY_SLOT = 1
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        Stall_IN,
   input  logic [31:0] AltPC_IN,
   input  logic        AltPCEnable_IN,
   output logic        IMemReq_OUT,
   output logic [31:0] IMemAddr_OUT,
   input  logic        IMemGnt_IN,
   input  logic [31:0] IMemRdata_IN,
   input  logic        IMemRvalid_IN,
   output logic [31:0] Instruction_OUT,
   output logic [31:0] InstructionAddressPlus4_OUT,
   output logic        Valid_OUT
);

   localparam int unsigned        CNT_W     = $clog2(BUF_DEPTH + 1);
   localparam int unsigned        SUM_W     = CNT_W + 1;
   localparam logic [SUM_W-1:0]   DEPTH_SUM = SUM_W'(BUF_DEPTH);
   localparam logic               KEEP_DS   = (DELAY_SLOT != 0);

   redirect_state_t state_q, state_d;
   logic [31:0]     pc_q, pc_d, alt_q, alt_d;
   logic            hold_q, hold_d;
   logic            kill_next_q, kill_next_d;
   // Per in-flight slot (0 = oldest) flag: response is to be discarded. This is the drop
   // count kept positionally, so a kept response behind dropped ones is never lost.
   logic [BUF_DEPTH-1:0] kill_q, kill_d, kill_v;

   logic [CNT_W-1:0] buf_count, fly_count;
   fetch_entry_t     buf_head, fly_head, buf_wdata, fly_wdata;
   logic             buf_push, buf_pop, buf_flush;

   logic req, grant, accept;
   logic keep_buf, keep_fly, keep_grant, any_live, grant_live, grant_kill, s_empty;
   int   keep_idx, gidx;
   logic unused_fly_instr;

   fetch_fifo #(.DEPTH(BUF_DEPTH)) u_ibuf (
      .clk   (CLOCK),
      .rst_n (RESET),
      .flush (buf_flush),
      .push  (buf_push),
      .wdata (buf_wdata),
      .pop   (buf_pop),
      .rdata (buf_head),
      .count (buf_count)
   );

   fetch_fifo #(.DEPTH(BUF_DEPTH)) u_addrq (
      .clk   (CLOCK),
      .rst_n (RESET),
      .flush (1'b0),
      .push  (grant),
      .wdata (fly_wdata),
      .pop   (IMemRvalid_IN),
      .rdata (fly_head),
      .count (fly_count)
   );

   assign unused_fly_instr = ^fly_head.instr;

   // Credits, handshake and redirect classification: which item of S survives a redirect.
   always_comb begin
      req        = ((SUM_W'(buf_count) + SUM_W'(fly_count)) < DEPTH_SUM) || hold_q;
      grant      = req && IMemGnt_IN;
      accept     = AltPCEnable_IN && !Stall_IN;
      keep_buf   = KEEP_DS && (buf_count != '0);
      any_live   = 1'b0;
      keep_idx   = 0;
      for (int i = BUF_DEPTH - 1; i >= 0; i--) begin
         if ((CNT_W'(i) < fly_count) && !kill_q[i]) begin
            any_live = 1'b1;
            keep_idx = i;
         end
      end
      keep_fly   = KEEP_DS && !keep_buf && any_live;
      grant_live = grant && !kill_next_q;
      keep_grant = KEEP_DS && (buf_count == '0) && !any_live && grant_live;
      s_empty    = (buf_count == '0) && !any_live && !grant_live;
      kill_v     = kill_q;
      if (accept) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            if ((CNT_W'(i) < fly_count) && !(keep_fly && (i == keep_idx))) kill_v[i] = 1'b1;
         end
      end
      grant_kill = kill_next_q || (accept && !keep_grant);
   end

   // Next-state: PC, pending redirect FSM, drop flags and buffer controls.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      alt_d       = alt_q;
      kill_next_d = kill_next_q;
      hold_d      = req && !IMemGnt_IN;

      if (grant) begin
         if (accept)                                pc_d = AltPC_IN;
         else if (kill_next_q || state_q == WAIT_DS) pc_d = alt_q;
         else                                       pc_d = pc_q + 32'd4;
         kill_next_d = 1'b0;
         state_d     = RUN;
      end else if (accept) begin
         if (KEEP_DS && s_empty && !kill_next_q) begin
            // The next sequential request becomes the delay slot.
            state_d = WAIT_DS;
            alt_d   = AltPC_IN;
         end else if (req) begin
            // The shown request cannot be withdrawn; drop it and redirect after its grant.
            kill_next_d = 1'b1;
            alt_d       = AltPC_IN;
         end else begin
            pc_d = AltPC_IN;
         end
      end

      kill_d = IMemRvalid_IN ? (kill_v >> 1) : kill_v;
      gidx   = int'(fly_count) - (IMemRvalid_IN ? 1 : 0);
      if (grant) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            if (i == gidx) kill_d[i] = grant_kill;
         end
      end

      buf_push        = IMemRvalid_IN && !kill_v[0];
      buf_wdata.instr = IMemRdata_IN;
      buf_wdata.pc4   = fly_head.pc4;
      buf_pop         = (buf_count != '0) && !Stall_IN;
      buf_flush       = accept && (!KEEP_DS || keep_buf);
      fly_wdata.instr = pc_q;
      fly_wdata.pc4   = pc_q + 32'd4;
   end

   // Pending-redirect state register.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) state_q <= RUN;
      else        state_q <= state_d;
   end

   // PC, latched target, handshake hold and drop bookkeeping.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         pc_q        <= RESET_PC;
         alt_q       <= '0;
         hold_q      <= 1'b0;
         kill_next_q <= 1'b0;
         kill_q      <= '0;
      end else begin
         pc_q        <= pc_d;
         alt_q       <= alt_d;
         hold_q      <= hold_d;
         kill_next_q <= kill_next_d;
         kill_q      <= kill_d;
      end
   end

   // Outputs; the head is replaced by a NOP with zero PC+4 when the buffer is empty.
   always_comb begin
      IMemReq_OUT                 = RESET && req;
      IMemAddr_OUT                = pc_q;
      Valid_OUT                   = (buf_count != '0);
      Instruction_OUT             = NOP_INSTR;
      InstructionAddressPlus4_OUT = 32'h0;
      if (buf_count != '0) begin
         Instruction_OUT             = buf_head.instr;
         InstructionAddressPlus4_OUT = buf_head.pc4;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit with a transaction-level reference model.
module tb_fetch_unit;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, alt_en = 1'b0, gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] alt_pc = 32'h0, rdata = 32'h0;
   logic        req, valid;
   logic [31:0] addr, instr, pc4;

   fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH), .DELAY_SLOT(1)) dut (
      .CLOCK                       (clk),
      .RESET                       (rst_n),
      .Stall_IN                    (stall),
      .AltPC_IN                    (alt_pc),
      .AltPCEnable_IN              (alt_en),
      .IMemReq_OUT                 (req),
      .IMemAddr_OUT                (addr),
      .IMemGnt_IN                  (gnt),
      .IMemRdata_IN                (rdata),
      .IMemRvalid_IN               (rvalid),
      .Instruction_OUT             (instr),
      .InstructionAddressPlus4_OUT (pc4),
      .Valid_OUT                   (valid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // S = live fetches in program order; arrived ones are the buffered prefix.
   typedef struct { logic [31:0] addr; int tag; bit arrived; } s_item_t;
   // Everything granted and not yet answered by memory, killed or not.
   typedef struct { logic [31:0] addr; int tag; int due; } mem_item_t;

   s_item_t     s_q[$];
   mem_item_t   mem_q[$];
   logic [31:0] m_pc, m_alt;
   bit          m_hold, m_wait, m_kill_next;
   int          cyc = 0, last_due = 0, next_tag = 0, lat_lo = 1, lat_hi = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   function automatic int n_arrived();
      int n = 0;
      foreach (s_q[i]) if (s_q[i].arrived) n++;
      return n;
   endfunction

   task automatic model_reset();
      s_q.delete();
      mem_q.delete();
      m_pc = RPC; m_alt = 32'h0;
      m_hold = 0; m_wait = 0; m_kill_next = 0;
      last_due = cyc;
      stall = 0; alt_en = 0; gnt = 0; rvalid = 0; rdata = 32'h0;
   endtask

   // Called at a negedge: compare outputs, drive one cycle of inputs, advance the model.
   task automatic step(input bit st, input bit en, input logic [31:0] a, input bit g);
      bit          e_req, e_valid, acc, grant_now, s_empty;
      logic [31:0] e_instr, e_pc4;
      int          tag, lat, due;
      e_req   = ((n_arrived() + mem_q.size()) < DEPTH) || m_hold;
      e_valid = (s_q.size() > 0) && s_q[0].arrived;
      e_instr = e_valid ? mem_word(s_q[0].addr) : 32'h0;
      e_pc4   = e_valid ? s_q[0].addr + 32'd4 : 32'h0;
      check("req", {31'b0, req}, {31'b0, e_req});
      if (e_req) check("addr", addr, m_pc);
      check("valid", {31'b0, valid}, {31'b0, e_valid});
      check("instr", instr, e_instr);
      check("pc4", pc4, e_pc4);

      stall = st; alt_en = en; alt_pc = a; gnt = g;
      rvalid = 1'b0; rdata = 32'h0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         rvalid = 1'b1;
         rdata  = mem_word(mem_q[0].addr);
      end

      acc       = en && !st;
      grant_now = e_req && g;
      if (rvalid) begin
         tag = mem_q[0].tag;
         void'(mem_q.pop_front());
         foreach (s_q[i]) if (s_q[i].tag == tag) s_q[i].arrived = 1;
      end
      if (grant_now) begin
         lat = int'($urandom_range(lat_hi, lat_lo));
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_q.push_back('{addr: m_pc, tag: next_tag, due: due});
         if (!m_kill_next) s_q.push_back('{addr: m_pc, tag: next_tag, arrived: 0});
         next_tag++;
      end
      s_empty = (s_q.size() == 0);
      if (acc) while (s_q.size() > 1) void'(s_q.pop_back());
      if (grant_now) begin
         if (acc)                         m_pc = a;
         else if (m_kill_next || m_wait)  m_pc = m_alt;
         else                             m_pc = m_pc + 32'd4;
         m_kill_next = 0;
         m_wait      = 0;
      end else if (acc) begin
         if (s_empty && !m_kill_next) begin m_wait = 1; m_alt = a; end
         else if (e_req)              begin m_kill_next = 1; m_alt = a; end
         else                         m_pc = a;
      end
      m_hold = e_req && !g;
      if (e_valid && !st) void'(s_q.pop_front());

      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_random(input int n, input int p_stall, input int p_gnt, input int p_redir);
      bit          st, en, g;
      logic [31:0] a;
      for (int k = 0; k < n; k++) begin
         st = ($urandom_range(99) < p_stall);
         g  = ($urandom_range(99) < p_gnt);
         en = !m_kill_next && ($urandom_range(99) < p_redir);
         a  = $urandom() & 32'hFFFF_FFFC;
         step(st, en, a, g);
      end
   endtask

   task automatic check_reset_outputs(input string phase);
      check({phase, "_req"},   {31'b0, req},   32'h0);
      check({phase, "_valid"}, {31'b0, valid}, 32'h0);
      check({phase, "_instr"}, instr,          32'h0);
      check({phase, "_pc4"},   pc4,            32'h0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Streaming with an always-granting, 1-cycle memory.
      lat_lo = 1; lat_hi = 1;
      repeat (8) step(0, 0, 32'h0, 1);
      // Decode stalls long enough for the buffer to fill, then releases.
      repeat (6) step(1, 0, 32'h0, 1);
      repeat (4) step(0, 0, 32'h0, 1);
      // Grant withheld for three cycles.
      repeat (3) step(0, 0, 32'h0, 0);
      repeat (4) step(0, 0, 32'h0, 1);
      // Redirect with a full buffer: head is the delay slot.
      repeat (3) step(1, 0, 32'h0, 1);
      step(0, 1, 32'h0040_0100, 1);
      repeat (6) step(0, 0, 32'h0, 1);
      // Redirect with S empty, overwritten while waiting for the delay-slot grant.
      repeat (5) step(0, 0, 32'h0, 0);
      step(0, 1, 32'h0040_0100, 0);
      step(0, 1, 32'h0040_0200, 0);
      repeat (6) step(0, 0, 32'h0, 1);
      // Redirect with two fetches in flight and 4-cycle memory latency.
      lat_lo = 4; lat_hi = 4;
      repeat (8) step(0, 0, 32'h0, 0);
      repeat (2) step(0, 0, 32'h0, 1);
      step(0, 1, 32'h0040_0300, 0);
      repeat (12) step(0, 0, 32'h0, 1);
      // Redirect near the top of the address space to exercise PC wrap-around.
      step(0, 1, 32'hFFFF_FFF8, 1);
      repeat (10) step(0, 0, 32'h0, 1);

      lat_lo = 1; lat_hi = 5;
      run_random(600, 25, 70, 8);

      // Reset in the middle of traffic.
      lat_lo = 3; lat_hi = 3;
      run_random(20, 10, 90, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      lat_lo = 1; lat_hi = 4;
      run_random(300, 20, 75, 10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
